// File: rtl/bus_transfer_sequencer_if.sv
// Command and bus-control bundle between the control unit (master) and the
// transfer sequencer (slave).
interface bus_transfer_sequencer_if;
  // Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready comes only from registered FIFO state, and the master holds
  // cmd_src/cmd_dst stable while cmd_valid is high.
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_src;
  logic [4:0]  cmd_dst;
  logic [31:0] src_out;
  logic [31:0] dst_in;
  logic [31:0] bus_data;
  logic [31:0] xfer_data;
  logic        xfer_done;
  logic        busy;
  logic [1:0]  dbg_state;

  modport master (
    output cmd_valid, cmd_src, cmd_dst, bus_data,
    input  cmd_ready, src_out, dst_in, xfer_data, xfer_done, busy, dbg_state
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst, bus_data,
    output cmd_ready, src_out, dst_in, xfer_data, xfer_done, busy, dbg_state
  );
endinterface

// File: rtl/bus_transfer_sequencer.sv
// Queues register-to-register transfer commands and sequences the one-hot
// bus-mux source selects and destination load enables for each one.
module bus_transfer_sequencer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int DRIVE_CYCLES = 1
) (
  input logic                      clk,
  input logic                      clear,
  bus_transfer_sequencer_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (DRIVE_CYCLES > 1) ? $clog2(DRIVE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] drive_cnt, drive_cnt_nxt;
  logic          pop;
  logic          push;
  logic          full;
  logic          empty;

  logic [9:0]    fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [4:0]    cur_src, cur_dst;
  logic [31:0]   xfer_data_q;
  logic          xfer_done_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = bus.cmd_valid && !full;

  always_comb begin
    state_nxt     = state;
    drive_cnt_nxt = drive_cnt;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop           = 1'b1;
          state_nxt     = DRIVE;
          drive_cnt_nxt = CW'(DRIVE_CYCLES - 1);
        end
      end
      DRIVE: begin
        if (drive_cnt == '0) state_nxt = LOAD;
        else                 drive_cnt_nxt = drive_cnt - CW'(1);
      end
      LOAD: begin
        // Chain straight into the next queued command with no IDLE bubble.
        if (!empty) begin
          pop           = 1'b1;
          state_nxt     = DRIVE;
          drive_cnt_nxt = CW'(DRIVE_CYCLES - 1);
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= IDLE;
      drive_cnt   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cur_src     <= '0;
      cur_dst     <= '0;
      xfer_data_q <= '0;
      xfer_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      drive_cnt   <= drive_cnt_nxt;
      xfer_done_q <= (state == LOAD);
      if (state == LOAD) xfer_data_q <= bus.bus_data;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) begin
        {cur_src, cur_dst} <= fifo_mem[rd_ptr[AW-1:0]];
        rd_ptr             <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Storage needs no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push && !clear) fifo_mem[wr_ptr[AW-1:0]] <= {bus.cmd_src, bus.cmd_dst};
  end

  assign bus.cmd_ready = !full;
  assign bus.src_out   = (state != IDLE) ? (32'd1 << cur_src) : 32'd0;
  assign bus.dst_in    = (state == LOAD) ? (32'd1 << cur_dst) : 32'd0;
  assign bus.xfer_data = xfer_data_q;
  assign bus.xfer_done = xfer_done_q;
  assign bus.busy      = (state != IDLE) || !empty;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Self-checking bench for bus_transfer_sequencer: one instance with the default
// drive length and one with DRIVE_CYCLES = 3, each fed by a one-hot mux model.
module tb_bus_transfer_sequencer;

  logic clk = 1'b0;
  logic clear1;
  logic clear3;
  int   tests_run    = 0;
  int   tests_failed = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  bus_transfer_sequencer_if b1 ();
  bus_transfer_sequencer_if b3 ();

  bus_transfer_sequencer #(.FIFO_DEPTH(4), .DRIVE_CYCLES(1)) u_dut1 (
    .clk(clk), .clear(clear1), .bus(b1)
  );
  bus_transfer_sequencer #(.FIFO_DEPTH(4), .DRIVE_CYCLES(3)) u_dut3 (
    .clk(clk), .clear(clear3), .bus(b3)
  );

  // Mux model: selected source i places 2**i on the bus (lowest select wins).
  function automatic logic [31:0] mux_model(input logic [31:0] sel);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 31; i >= 0; i--) if (sel[i]) r = 32'd1 << i;
    return r;
  endfunction

  assign b1.bus_data = mux_model(b1.src_out);
  assign b3.bus_data = mux_model(b3.src_out);

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    clear1 = 1'b1; clear3 = 1'b1;
    b1.cmd_valid = 1'b0; b1.cmd_src = '0; b1.cmd_dst = '0;
    b3.cmd_valid = 1'b0; b3.cmd_src = '0; b3.cmd_dst = '0;
    repeat (2) @(negedge clk);
    tests_run++; if (b1.src_out !== 32'h0) begin tests_failed++; $display("FAIL reset src_out: got %h want 0", b1.src_out); end
    tests_run++; if (b1.dst_in !== 32'h0) begin tests_failed++; $display("FAIL reset dst_in: got %h want 0", b1.dst_in); end
    tests_run++; if (b1.xfer_data !== 32'h0) begin tests_failed++; $display("FAIL reset xfer_data: got %h want 0", b1.xfer_data); end
    tests_run++; if (b1.xfer_done !== 1'b0) begin tests_failed++; $display("FAIL reset xfer_done: got %b want 0", b1.xfer_done); end
    tests_run++; if (b1.busy !== 1'b0) begin tests_failed++; $display("FAIL reset busy: got %b want 0", b1.busy); end
    tests_run++; if (b1.cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset cmd_ready: got %b want 1", b1.cmd_ready); end
    tests_run++; if (b3.src_out !== 32'h0 || b3.cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset dut3: src_out %h ready %b want 0/1", b3.src_out, b3.cmd_ready); end
    clear1 = 1'b0; clear3 = 1'b0;
  endtask

  task automatic test_single();
    logic [31:0] e_src [5];
    logic [31:0] e_dst [5];
    logic        e_done[5];
    logic        e_busy[5];
    logic [31:0] e;
    e_src  = '{32'h0, 32'h8, 32'h8, 32'h0, 32'h0};
    e_dst  = '{32'h0, 32'h0, 32'h80, 32'h0, 32'h0};
    e_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    e_busy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_q.delete();
    b1.cmd_valid = 1'b1; b1.cmd_src = 5'd3; b1.cmd_dst = 5'd7;
    exp_q.push_back(32'h8);
    @(negedge clk);
    b1.cmd_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      tests_run++; if (b1.src_out !== e_src[c]) begin tests_failed++; $display("FAIL single src_out c%0d: got %h want %h", c, b1.src_out, e_src[c]); end
      tests_run++; if (b1.dst_in !== e_dst[c]) begin tests_failed++; $display("FAIL single dst_in c%0d: got %h want %h", c, b1.dst_in, e_dst[c]); end
      tests_run++; if (b1.xfer_done !== e_done[c]) begin tests_failed++; $display("FAIL single xfer_done c%0d: got %b want %b", c, b1.xfer_done, e_done[c]); end
      tests_run++; if (b1.busy !== e_busy[c]) begin tests_failed++; $display("FAIL single busy c%0d: got %b want %b", c, b1.busy, e_busy[c]); end
      if (b1.xfer_done === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests_run++; if (b1.xfer_data !== e) begin tests_failed++; $display("FAIL single xfer_data: got %h want %h", b1.xfer_data, e); end
      end
    end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL single pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  srcs [3];
    logic [4:0]  dsts [3];
    logic [31:0] e_src[8];
    logic [31:0] e;
    int          done_cyc[$];
    srcs  = '{5'd20, 5'd21, 5'd23};
    dsts  = '{5'd21, 5'd0, 5'd31};
    e_src = '{32'h0, 32'h100000, 32'h100000, 32'h200000, 32'h200000, 32'h800000, 32'h800000, 32'h0};
    exp_q.delete();
    for (int c = 0; c < 10; c++) begin
      if (c < 3) begin
        b1.cmd_valid = 1'b1; b1.cmd_src = srcs[c]; b1.cmd_dst = dsts[c];
        if (b1.cmd_ready === 1'b1) exp_q.push_back(32'd1 << srcs[c]);
      end else begin
        b1.cmd_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 8) begin
        tests_run++; if (b1.src_out !== e_src[c]) begin tests_failed++; $display("FAIL b2b src_out c%0d: got %h want %h", c, b1.src_out, e_src[c]); end
      end
      if (b1.xfer_done === 1'b1) begin
        done_cyc.push_back(c);
        tests_run++;
        if (exp_q.size() == 0) begin tests_failed++; $display("FAIL b2b extra xfer_done: got pulse at c%0d want none", c); end
        else begin
          e = exp_q.pop_front();
          if (b1.xfer_data !== e) begin tests_failed++; $display("FAIL b2b xfer_data: got %h want %h", b1.xfer_data, e); end
        end
      end
    end
    tests_run++; if (done_cyc.size() != 3) begin tests_failed++; $display("FAIL b2b done count: got %0d want 3", done_cyc.size()); end
    else begin
      tests_run++; if (done_cyc[1] - done_cyc[0] != 2 || done_cyc[2] - done_cyc[1] != 2) begin tests_failed++; $display("FAIL b2b done spacing: got %0d,%0d want 2,2", done_cyc[1] - done_cyc[0], done_cyc[2] - done_cyc[1]); end
    end
    tests_run++; if (b1.xfer_data !== 32'h00800000) begin tests_failed++; $display("FAIL b2b final xfer_data: got %h want 00800000", b1.xfer_data); end
  endtask

  task automatic test_drive3();
    logic [31:0] e_src [7];
    logic [31:0] e_dst [7];
    logic        e_done[7];
    e_src  = '{32'h0, 32'h10000, 32'h10000, 32'h10000, 32'h10000, 32'h0, 32'h0};
    e_dst  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h20000, 32'h0, 32'h0};
    e_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    b3.cmd_valid = 1'b1; b3.cmd_src = 5'd16; b3.cmd_dst = 5'd17;
    @(negedge clk);
    b3.cmd_valid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      tests_run++; if (b3.src_out !== e_src[c]) begin tests_failed++; $display("FAIL drive3 src_out c%0d: got %h want %h", c, b3.src_out, e_src[c]); end
      tests_run++; if (b3.dst_in !== e_dst[c]) begin tests_failed++; $display("FAIL drive3 dst_in c%0d: got %h want %h", c, b3.dst_in, e_dst[c]); end
      tests_run++; if (b3.xfer_done !== e_done[c]) begin tests_failed++; $display("FAIL drive3 xfer_done c%0d: got %b want %b", c, b3.xfer_done, e_done[c]); end
    end
    tests_run++; if (b3.xfer_data !== 32'h10000) begin tests_failed++; $display("FAIL drive3 xfer_data: got %h want 00010000", b3.xfer_data); end
  endtask

  task automatic test_full();
    logic        exp_acc[6];
    logic [31:0] e;
    int          dones = 0;
    bit          saw_rejected = 0;
    exp_acc = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_q.delete();
    for (int c = 0; c < 30; c++) begin
      if (c < 6) begin
        b3.cmd_valid = 1'b1; b3.cmd_src = 5'(c + 1); b3.cmd_dst = 5'(c + 8);
        tests_run++; if (b3.cmd_ready !== exp_acc[c]) begin tests_failed++; $display("FAIL full cmd_ready push%0d: got %b want %b", c, b3.cmd_ready, exp_acc[c]); end
        if (b3.cmd_ready === 1'b1) exp_q.push_back(32'd1 << (c + 1));
      end else begin
        b3.cmd_valid = 1'b0;
      end
      @(negedge clk);
      if (b3.src_out[6] === 1'b1) saw_rejected = 1;
      if (b3.xfer_done === 1'b1) begin
        dones++;
        tests_run++;
        if (exp_q.size() == 0) begin tests_failed++; $display("FAIL full extra xfer_done: got pulse at c%0d want none", c); end
        else begin
          e = exp_q.pop_front();
          if (b3.xfer_data !== e) begin tests_failed++; $display("FAIL full xfer_data order: got %h want %h", b3.xfer_data, e); end
        end
      end
    end
    tests_run++; if (dones != 5) begin tests_failed++; $display("FAIL full completed count: got %0d want 5", dones); end
    tests_run++; if (saw_rejected) begin tests_failed++; $display("FAIL full rejected cmd driven: got src 6 on bus want never"); end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL full pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_clear_mid();
    logic [4:0]  srcs[3];
    logic [4:0]  dsts[3];
    logic [31:0] e;
    int          late_dones = 0;
    srcs = '{5'd1, 5'd4, 5'd9};
    dsts = '{5'd2, 5'd5, 5'd10};
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      if (c < 3) begin
        b1.cmd_valid = 1'b1; b1.cmd_src = srcs[c]; b1.cmd_dst = dsts[c];
        if (b1.cmd_ready === 1'b1) exp_q.push_back(32'd1 << srcs[c]);
      end else begin
        b1.cmd_valid = 1'b0;
      end
      @(negedge clk);
      if (b1.xfer_done === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests_run++; if (b1.xfer_data !== e) begin tests_failed++; $display("FAIL clear first xfer_data: got %h want %h", b1.xfer_data, e); end
      end
    end
    tests_run++; if (b1.src_out !== 32'h10 || b1.dst_in !== 32'h0) begin tests_failed++; $display("FAIL clear pre-state: got src %h dst %h want 00000010/0", b1.src_out, b1.dst_in); end
    clear1 = 1'b1;
    @(negedge clk);
    clear1 = 1'b0;
    exp_q.delete();
    tests_run++; if (b1.src_out !== 32'h0) begin tests_failed++; $display("FAIL clear src_out: got %h want 0", b1.src_out); end
    tests_run++; if (b1.dst_in !== 32'h0) begin tests_failed++; $display("FAIL clear dst_in: got %h want 0", b1.dst_in); end
    tests_run++; if (b1.xfer_data !== 32'h0) begin tests_failed++; $display("FAIL clear xfer_data: got %h want 0", b1.xfer_data); end
    tests_run++; if (b1.busy !== 1'b0) begin tests_failed++; $display("FAIL clear busy: got %b want 0", b1.busy); end
    tests_run++; if (b1.cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL clear cmd_ready: got %b want 1", b1.cmd_ready); end
    for (int c = 0; c < 6; c++) begin
      if (b1.xfer_done !== 1'b0 || b1.src_out !== 32'h0) late_dones++;
      @(negedge clk);
    end
    tests_run++; if (late_dones != 0) begin tests_failed++; $display("FAIL clear residual activity: got %0d cycles want 0", late_dones); end
  endtask

  task automatic test_random();
    logic [31:0] e;
    logic [4:0]  s, d;
    int          pushed = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (pushed < 40) begin
        s = 5'($urandom_range(0, 31));
        d = 5'($urandom_range(0, 31));
        b1.cmd_valid = ($urandom_range(0, 1) == 1) || (pushed == 20);
        if (pushed == 20) begin s = 5'd31; d = 5'd31; end
        b1.cmd_src = s; b1.cmd_dst = d;
        if (b1.cmd_valid && b1.cmd_ready === 1'b1) begin
          exp_q.push_back(32'd1 << s);
          pushed++;
        end
      end else begin
        b1.cmd_valid = 1'b0;
      end
      @(negedge clk);
      tests_run++; if ($countones(b1.src_out) > 1) begin tests_failed++; $display("FAIL onehot src_out: got %h want <=1 bit", b1.src_out); end
      tests_run++; if ($countones(b1.dst_in) > 1) begin tests_failed++; $display("FAIL onehot dst_in: got %h want <=1 bit", b1.dst_in); end
      if (b1.xfer_done === 1'b1) begin
        tests_run++;
        if (exp_q.size() == 0) begin tests_failed++; $display("FAIL random extra xfer_done: got pulse want none"); end
        else begin
          e = exp_q.pop_front();
          if (b1.xfer_data !== e) begin tests_failed++; $display("FAIL random xfer_data: got %h want %h", b1.xfer_data, e); end
        end
      end
    end
    tests_run++; if (pushed != 40 || exp_q.size() != 0) begin tests_failed++; $display("FAIL random drain: got pushed %0d pending %0d want 40/0", pushed, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_drive3();
    test_full();
    test_clear_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
